// File: rtl/uart_rx_param_pkg.sv
// Shared types and defaults for the parametrised UART receiver.
// Optional parity support is enabled with the UART_RX_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_STOP_BITS  = 1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_TICK_W = cnt_w(DEF_OVERSAMPLE);
    localparam int DEF_BIT_W  = cnt_w(DEF_DATA_BITS + 1);

endpackage

// File: rtl/uart_rx_param_if.sv
// Serial-in / word-out bundle of the UART receiver.
// The receiver drives the word side through the master modport.
interface uart_rx_param_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) ();

    logic                 rx;
    logic                 s_tick;
    logic [DATA_BITS-1:0] d_out;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        input  rx,
        input  s_tick,
        output d_out,
        output rx_valid,
        output frame_err,
        output parity_err,
        output busy
    );

    modport slave (
        output rx,
        output s_tick,
        input  d_out,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );

endinterface

// File: rtl/uart_rx_param_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both flops reset to the idle (high) line level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    output logic rx_s_o
);

    logic s1_q;
    logic s2_q;

    // Resample rx twice before any decision is taken on it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= rx_i;
            s2_q <= s1_q;
        end
    end

    assign rx_s_o = s2_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with mid-bit sampling and break handling.
// Define UART_RX_PARITY_EN to add a checked parity bit after the data.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int STOP_BITS  = DEF_STOP_BITS,
    parameter int PARITY_ODD = 0
) (
    input logic             clk,
    input logic             reset,
    uart_rx_param_if.master bus
);

    localparam int TW = cnt_w(OVERSAMPLE);
    localparam int BW = cnt_w(DATA_BITS + 1);
    localparam logic [TW-1:0] T_HALF  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_DLAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_SLAST = BW'(STOP_BITS - 1);

    logic rx_s;

    rx_state_e            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .rx_i   (bus.rx),
        .rx_s_o (rx_s)
    );

`ifndef UART_RX_PARITY_EN
    // Parity sense only matters when the parity bit is present.
    logic unused_par;
    assign unused_par = PARITY_ODD[0];
`endif

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    // Frame sequencing; counters only move on oversampling ticks.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (tick_q == T_HALF) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                            fe_d    = 1'b0;
                            pe_d    = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (tick_q == T_LAST) begin
                        tick_d  = '0;
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == B_DLAST) begin
                            bit_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bus.s_tick) begin
                    if (tick_q == T_LAST) begin
                        tick_d  = '0;
                        pe_d    = ((^shreg_q) ^ rx_s) != PARITY_ODD[0];
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (bus.s_tick) begin
                    if (tick_q == T_LAST) begin
                        tick_d = '0;
                        fe_d   = fe_q | ~rx_s;
                        if (bit_q == B_SLAST) begin
                            bit_d   = '0;
                            valid_d = 1'b1;
                            dout_d  = shreg_q;
                            ferr_d  = fe_q | ~rx_s;
                            perr_d  = pe_q;
                            state_d = rx_s ? IDLE : BREAK;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.d_out      = dout_q;
    assign bus.rx_valid   = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.parity_err = perr_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 instance plus a 7-bit, 2-stop instance.
// Frames carry a parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_rx_param;

`ifdef UART_RX_PARITY_EN
    localparam int HAS_PAR = 1;
`else
    localparam int HAS_PAR = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic s_tick = 1'b0;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    int   div = 2;

    int errors = 0;
    int checks = 0;

    int         cnt0 = 0;
    int         cnt1 = 0;
    logic [8:0] d0, d1;
    logic       fe0, fe1, pe0, pe1;
    logic [8:0] log0[$];

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(7)) if1 ();

    assign if0.rx     = rx0;
    assign if1.rx     = rx1;
    assign if0.s_tick = s_tick;
    assign if1.s_tick = s_tick;

    uart_rx_param u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    uart_rx_param #(
        .DATA_BITS  (7),
        .OVERSAMPLE (16),
        .STOP_BITS  (2),
        .PARITY_ODD (0)
    ) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if0.rx_valid) begin
            cnt0 = cnt0 + 1;
            d0   = {1'b0, if0.d_out};
            fe0  = if0.frame_err;
            pe0  = if0.parity_err;
            log0.push_back({1'b0, if0.d_out});
        end
        if (if1.rx_valid) begin
            cnt1 = cnt1 + 1;
            d1   = {2'b00, if1.d_out};
            fe1  = if1.frame_err;
            pe1  = if1.parity_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        s_tick = 1'b1;
        @(negedge clk);
        s_tick = 1'b0;
        repeat (div - 1) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic set_rx(input int sel, input logic b);
        if (sel == 0) rx0 = b;
        else rx1 = b;
    endtask

    task automatic send_bit(input int sel, input logic b);
        set_rx(sel, b);
        ticks(16);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data,
                              input int nbits, input logic flip_par,
                              input int nstop, input logic [1:0] stops);
        logic par;
        par = flip_par;
        send_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            send_bit(sel, data[i]);
            par = par ^ data[i];
        end
        if (HAS_PAR != 0) send_bit(sel, par);
        for (int i = 0; i < nstop; i++) send_bit(sel, stops[i]);
        set_rx(sel, 1'b1);
    endtask

    initial begin
        int base;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_valid", {31'b0, if0.rx_valid}, 32'd0);
        chk("rst_dout", {24'b0, if0.d_out}, 32'd0);
        chk("rst_ferr", {31'b0, if0.frame_err}, 32'd0);
        chk("rst_perr", {31'b0, if0.parity_err}, 32'd0);
        chk("rst_busy0", {31'b0, if0.busy}, 32'd0);
        chk("rst_busy1", {31'b0, if1.busy}, 32'd0);
        reset = 1'b1;
        ticks(8);

        // 8N1 frame 0xA5
        send_frame(0, 9'h0A5, 8, 1'b0, 1, 2'b11);
        ticks(32);
        chk("a5_cnt", cnt0, 32'd1);
        chk("a5_dout", {23'b0, d0}, 32'hA5);
        chk("a5_ferr", {31'b0, fe0}, 32'd0);
        chk("a5_perr", {31'b0, pe0}, 32'd0);
        chk("a5_busy", {31'b0, if0.busy}, 32'd0);

        // false start: 4 ticks low
        rx0 = 1'b0;
        ticks(2);
        chk("fs_busy_hi", {31'b0, if0.busy}, 32'd1);
        ticks(2);
        rx0 = 1'b1;
        ticks(32);
        chk("fs_cnt", cnt0, 32'd1);
        chk("fs_busy_lo", {31'b0, if0.busy}, 32'd0);

        // framing error followed by a long break
        send_frame(0, 9'h000, 8, 1'b0, 1, 2'b00);
        rx0 = 1'b0;
        ticks(40 * 16);
        chk("fe_cnt", cnt0, 32'd2);
        chk("fe_dout", {23'b0, d0}, 32'h00);
        chk("fe_ferr", {31'b0, fe0}, 32'd1);
        chk("brk_busy", {31'b0, if0.busy}, 32'd1);
        rx0 = 1'b1;
        ticks(32);
        chk("brk_cnt", cnt0, 32'd2);
        chk("brk_idle", {31'b0, if0.busy}, 32'd0);
        send_frame(0, 9'h03C, 8, 1'b0, 1, 2'b11);
        ticks(32);
        chk("3c_cnt", cnt0, 32'd3);
        chk("3c_dout", {23'b0, d0}, 32'h3C);
        chk("3c_ferr", {31'b0, fe0}, 32'd0);

        // 7-bit, 2-stop instance
        send_frame(1, 9'h041, 7, 1'b0, 2, 2'b11);
        ticks(32);
        chk("41_cnt", cnt1, 32'd1);
        chk("41_dout", {23'b0, d1}, 32'h41);
        chk("41_ferr", {31'b0, fe1}, 32'd0);
        send_frame(1, 9'h041, 7, 1'b0, 2, 2'b01);
        ticks(32);
        chk("41s2_cnt", cnt1, 32'd2);
        chk("41s2_ferr", {31'b0, fe1}, 32'd1);
        chk("41s2_busy", {31'b0, if1.busy}, 32'd0);
`ifdef UART_RX_PARITY_EN
        send_frame(1, 9'h041, 7, 1'b1, 2, 2'b11);
        ticks(32);
        chk("par_bad_dout", {23'b0, d1}, 32'h41);
        chk("par_bad", {31'b0, pe1}, 32'd1);
        send_frame(1, 9'h041, 7, 1'b0, 2, 2'b11);
        ticks(32);
        chk("par_good", {31'b0, pe1}, 32'd0);
        chk("par_cnt", cnt1, 32'd4);
`endif

        // reset mid-data of 0x55, then 0x0F
        base = cnt0;
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        rx0 = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rr_busy", {31'b0, if0.busy}, 32'd0);
        chk("rr_dout", {24'b0, if0.d_out}, 32'd0);
        ticks(64);
        chk("rr_nopulse", cnt0, base);
        send_frame(0, 9'h00F, 8, 1'b0, 1, 2'b11);
        ticks(32);
        chk("0f_cnt", cnt0, base + 1);
        chk("0f_dout", {23'b0, d0}, 32'h0F);

        // back-to-back frames, tick every 3 clocks
        div = 3;
        base = cnt0;
        send_frame(0, 9'h012, 8, 1'b0, 1, 2'b11);
        send_frame(0, 9'h034, 8, 1'b0, 1, 2'b11);
        ticks(32);
        chk("b2b_cnt", cnt0, base + 2);
        if (log0.size() >= 2) begin
            chk("b2b_first", {23'b0, log0[log0.size() - 2]}, 32'h12);
            chk("b2b_second", {23'b0, log0[log0.size() - 1]}, 32'h34);
        end else begin
            chk("b2b_log", log0.size(), 32'd2);
        end
        chk("b2b_ferr", {31'b0, fe0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
